fifo_pop_counter_bank: RTL

Per-channel pop counter bank for the FIFO subsystem: counts pop strobes on `NUM_CH` FIFO channels and returns one channel's count on request while the datapath is idle. Parametrised in channel count, counter width and overflow mode, with optional clear-on-read and sticky overflow flags. Sits beside the FIFO array and is read by the controller when the controller asserts `idle`.

---
 rtl/fifo_pop_counter_bank.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_pop_counter_bank.sv
// fifo_pop_counter_bank
//
// Per-channel pop counter bank for the FIFO subsystem. It counts pop strobes
// on NUM_CH channels and returns one channel's count when the controller
// requests it while the datapath is idle.
//
// Parameters
//   NUM_CH        number of counted channels (1..8)
//   CNT_W         counter width
//   IDX_W         channel index width, 2^IDX_W >= NUM_CH
//   SATURATE      0: counters wrap modulo 2^CNT_W, 1: counters hold at max
//   CLEAR_ON_READ 1: an accepted in-range read zeroes that channel's counter
//                 and clears its overflow flag
//
// Ports
//   clk       system clock, rising edge
//   reset_L   asynchronous active-low reset
//   pop       per-channel pop strobes, one count per cycle high
//   idle      controller idle; reads are accepted only while high
//   req       read request, sampled each cycle
//   idx       channel to read, sampled with req
//   valid     one-cycle pulse, data_out holds a read result
//   data_out  count of the requested channel (held when valid is low)
//   req_err   one-cycle pulse, accepted read had idx >= NUM_CH
//   overflow  sticky per-channel overflow flags
module fifo_pop_counter_bank #(
    parameter int NUM_CH        = 5,
    parameter int CNT_W         = 5,
    parameter int IDX_W         = 3,
    parameter int SATURATE      = 0,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NUM_CH-1:0] pop,
    input  logic              idle,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic [CNT_W-1:0]  data_out,
    output logic              req_err,
    output logic [NUM_CH-1:0] overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // One extra bit so that NUM_CH = 2^IDX_W is still representable.
    localparam logic [IDX_W:0]   NUM_CH_L = (IDX_W+1)'(NUM_CH);

    // Increment with wrap or saturation at the top of the counter range.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX)
            return (SATURATE != 0) ? CNT_MAX : '0;
        return c + 1'b1;
    endfunction

    logic [CNT_W-1:0] cnt [NUM_CH];
    logic             accept;
    logic             in_range;
    logic [CNT_W-1:0] rd_cnt;
    logic [IDX_W:0]   idx_ext;

    always_comb begin
        idx_ext  = {1'b0, idx};
        accept   = req & idle;
        in_range = (idx_ext < NUM_CH_L);
        // Explicit mux so an out-of-range index never indexes past the array.
        rd_cnt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx_ext == (IDX_W+1)'(i))
                rd_cnt = cnt[i];
        end
    end

    // Counter and overflow update
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((CLEAR_ON_READ != 0) && accept && in_range &&
                    (idx_ext == (IDX_W+1)'(i))) begin
                    // A pop on the read edge is the first count after clear;
                    // it can never overflow, so the flag always clears.
                    cnt[i]      <= CNT_W'(pop[i]);
                    overflow[i] <= 1'b0;
                end else if (pop[i]) begin
                    cnt[i] <= next_count(cnt[i]);
                    if (cnt[i] == CNT_MAX)
                        overflow[i] <= 1'b1;
                end
            end
        end
    end

    // Read response, registered; data_out reflects counts before this edge
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid    <= 1'b0;
            req_err  <= 1'b0;
            data_out <= '0;
        end else begin
            valid   <= accept & in_range;
            req_err <= accept & ~in_range;
            if (accept && in_range)
                data_out <= rd_cnt;
        end
    end

endmodule
